// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the parametrised AXI-Stream packet FIFO.
// The beat struct is a macro so each FIFO instance can stamp out a
// struct sized to its own DATA_W without a parametrised package.
`ifndef AXIS_FIFO_PKG_SV
`define AXIS_FIFO_PKG_SV

// Stored beat layout: {tlast, tkeep, tdata}, tlast in the MSB.
`define AXIS_BEAT_T(DW) struct packed { logic last; logic [((DW)/8)-1:0] keep; logic [(DW)-1:0] data; }

package axis_fifo_pkg;

  // Smallest legal depth; below this full/almost_full become degenerate.
  localparam int AXIS_FIFO_MIN_DEPTH = 4;

  // Ceiling log2 that never returns 0, so address buses are at least 1 bit.
  function automatic int clog2_safe(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage array for the FIFO: synchronous write,
// asynchronous (combinational) read so the head entry falls through.
module axis_fifo_mem
  import axis_fifo_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];

  // Store the incoming beat at the write address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Parametrised single-clock AXI-Stream FIFO with fill level, packet count,
// almost_full flag and an optional store-and-forward (packet) mode.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0,
  parameter int AF_THRESH   = DEPTH - 2,
  localparam int KEEP_W     = DATA_W / 8
) (
  input  logic                     Aclk,
  input  logic                     Areset_n,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic [KEEP_W-1:0]        s_axis_tkeep,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [KEEP_W-1:0]        m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     almost_full
);

  localparam int AW = clog2_safe(DEPTH);
  localparam int PW = AW + 1;

  typedef `AXIS_BEAT_T(DATA_W) beat_t;
  localparam int BEAT_W = $bits(beat_t);

  localparam logic [PW-1:0] ONE      = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);

  // Reject configurations the pointer arithmetic cannot support.
  if (DEPTH < AXIS_FIFO_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0 || (DATA_W % 8) != 0) begin : g_param_check
    $error("axis_pkt_fifo: DEPTH must be a power of two >= 4 and DATA_W a multiple of 8");
  end

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     level_q, level_d;
  logic [PW-1:0]     pkt_q, pkt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              af_q, af_d;

  logic              push, pop, push_last, pop_last;
  logic              full_nxt, empty_nxt;
  beat_t             wbeat, rbeat;
  logic [BEAT_W-1:0] rdata_raw;

  assign wbeat = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};
  assign rbeat = beat_t'(rdata_raw);

  axis_fifo_mem #(
    .WIDTH (BEAT_W),
    .AW    (AW)
  ) u_mem (
    .clk_i   (Aclk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wbeat),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata_raw)
  );

  // Handshakes and next-state for pointers, counters and the registered flags.
  always_comb begin
    push      = s_axis_tvalid & ready_q;
    pop       = valid_q & m_axis_tready;
    push_last = push & s_axis_tlast;
    pop_last  = pop & rbeat.last;

    wr_ptr_d  = wr_ptr_q + {{(PW-1){1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{(PW-1){1'b0}}, pop};

    case ({push, pop})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase

    case ({push_last, pop_last})
      2'b10:   pkt_d = pkt_q + ONE;
      2'b01:   pkt_d = pkt_q - ONE;
      default: pkt_d = pkt_q;
    endcase

    full_nxt  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_nxt = (wr_ptr_d == rd_ptr_d);

    // In packet mode a full FIFO releases its head so over-long packets cannot deadlock.
    valid_d   = !empty_nxt && ((PACKET_MODE == 0) || (pkt_d != {PW{1'b0}}) || full_nxt);
    ready_d   = !full_nxt;
    af_d      = (level_d >= AF_LEVEL);
  end

  // State registers; reset flushes everything, including partial packets.
  always_ff @(posedge Aclk or negedge Areset_n) begin
    if (!Areset_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {PW{1'b0}};
      pkt_q    <= {PW{1'b0}};
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      af_q     <= af_d;
    end
  end

  // Payload is forced to zero whenever no beat is offered, which also gives zeros in reset.
  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = valid_q ? rbeat.data : {DATA_W{1'b0}};
  assign m_axis_tkeep  = valid_q ? rbeat.keep : {KEEP_W{1'b0}};
  assign m_axis_tlast  = valid_q & rbeat.last;
  assign s_axis_tready = ready_q;
  assign level         = level_q;
  assign pkt_count     = pkt_q;
  assign almost_full   = af_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: one cut-through and one packet-mode instance,
// checked every cycle against a queue-based model of the FIFO contents.
module tb_axis_pkt_fifo;

  localparam int D = 16;

  typedef logic [9:0] beat_t; // {last, keep, data}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_sv, a_sr, a_sk, a_sl, a_mv, a_mr, a_mk, a_ml, a_af;
  logic [7:0] a_sd, a_md;
  logic [4:0] a_lvl, a_pkt;
  logic       b_sv, b_sr, b_sk, b_sl, b_mv, b_mr, b_mk, b_ml, b_af;
  logic [7:0] b_sd, b_md;
  logic [4:0] b_lvl, b_pkt;

  beat_t qa[$];
  beat_t qb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_W(8), .DEPTH(D), .PACKET_MODE(0)) dut_a (
    .Aclk(clk), .Areset_n(rst_n),
    .s_axis_tvalid(a_sv), .s_axis_tready(a_sr), .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tlast(a_sl),
    .m_axis_tvalid(a_mv), .m_axis_tready(a_mr), .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tlast(a_ml),
    .level(a_lvl), .pkt_count(a_pkt), .almost_full(a_af)
  );

  axis_pkt_fifo #(.DATA_W(8), .DEPTH(D), .PACKET_MODE(1)) dut_b (
    .Aclk(clk), .Areset_n(rst_n),
    .s_axis_tvalid(b_sv), .s_axis_tready(b_sr), .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tlast(b_sl),
    .m_axis_tvalid(b_mv), .m_axis_tready(b_mr), .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tlast(b_ml),
    .level(b_lvl), .pkt_count(b_pkt), .almost_full(b_af)
  );

  function automatic int n_last(input beat_t q[$]);
    int n = 0;
    foreach (q[i]) if (q[i][9]) n++;
    return n;
  endfunction

  // Expected tvalid from the stored contents: any beat (cut-through) or a whole packet / full FIFO.
  function automatic logic exp_valid(input bit pkt_mode, input beat_t q[$]);
    if (q.size() == 0) return 1'b0;
    if (!pkt_mode) return 1'b1;
    return (n_last(q) != 0) || (q.size() == D);
  endfunction

  task automatic drive_a(input logic v, input beat_t b);
    a_sv = v; {a_sl, a_sk, a_sd} = b;
  endtask

  task automatic drive_b(input logic v, input beat_t b);
    b_sv = v; {b_sl, b_sk, b_sd} = b;
  endtask

  task automatic idle();
    drive_a(1'b0, 10'd0); drive_b(1'b0, 10'd0); a_mr = 1'b0; b_mr = 1'b0;
  endtask

  // One clock edge; the model applies the handshakes the FIFO rules imply.
  task automatic step();
    bit pa, qa_pop, pb, qb_pop;
    beat_t ba, bb;
    pa = a_sv && (qa.size() < D) && rst_n;
    pb = b_sv && (qb.size() < D) && rst_n;
    qa_pop = exp_valid(1'b0, qa) && a_mr;
    qb_pop = exp_valid(1'b1, qb) && b_mr;
    ba = {a_sl, a_sk, a_sd};
    bb = {b_sl, b_sk, b_sd};
    @(posedge clk);
    if (qa_pop) void'(qa.pop_front());
    if (pa) qa.push_back(ba);
    if (qb_pop) void'(qb.pop_front());
    if (pb) qb.push_back(bb);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (a_sr !== 1'b0 || b_sr !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b/%b want 0/0", a_sr, b_sr); end
    n_checks++; if (a_mv !== 1'b0 || b_mv !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b/%b want 0/0", a_mv, b_mv); end
    n_checks++; if (a_lvl !== 5'd0 || a_pkt !== 5'd0 || a_af !== 1'b0) begin n_fail++; $display("FAIL reset_counters: got lvl=%0d pkt=%0d af=%b want 0 0 0", a_lvl, a_pkt, a_af); end
    n_checks++; if ({a_md, a_mk, a_ml} !== 10'd0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", {a_md, a_mk, a_ml}); end
    rst_n = 1'b1;
    qa.delete(); qb.delete();
    n_checks++; if (a_sr !== 1'b0) begin n_fail++; $display("FAIL release_tready_early: got %b want 0", a_sr); end
    step();
    n_checks++; if (a_sr !== 1'b1 || b_sr !== 1'b1) begin n_fail++; $display("FAIL release_tready: got %b/%b want 1/1", a_sr, b_sr); end
  endtask

  // Fill with the sink stalled; the 17th beat is then held upstream.
  task automatic test_fill();
    beat_t b;
    a_mr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i <= 16) b = {1'b0, 9'($urandom)};
      drive_a(1'b1, b);
      n_checks++; if (a_sr !== (qa.size() < D)) begin n_fail++; $display("FAIL fill_tready[%0d]: got %b want %b", i, a_sr, qa.size() < D); end
      n_checks++; if (a_lvl !== 5'(qa.size())) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, a_lvl, qa.size()); end
      n_checks++; if (a_af !== (qa.size() >= 14)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, a_af, qa.size() >= 14); end
      n_checks++; if (a_mv !== exp_valid(1'b0, qa)) begin n_fail++; $display("FAIL fill_tvalid[%0d]: got %b", i, a_mv); end
      step();
    end
    n_checks++; if (a_lvl !== 5'd16 || a_sr !== 1'b0) begin n_fail++; $display("FAIL fill_full: got lvl=%0d tready=%b want 16 0", a_lvl, a_sr); end
  endtask

  // Drain everything (the held beat enters once space appears), then check single-beat latency.
  task automatic test_drain();
    beat_t b;
    a_mr = 1'b1;
    for (int i = 0; i < 40 && (qa.size() != 0 || a_sv); i++) begin
      bit acc;
      acc = a_sv && (qa.size() < D);
      n_checks++; if (a_mv !== exp_valid(1'b0, qa)) begin n_fail++; $display("FAIL drain_tvalid[%0d]: got %b", i, a_mv); end
      if (qa.size() != 0) begin
        n_checks++; if ({a_ml, a_mk, a_md} !== qa[0]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, {a_ml, a_mk, a_md}, qa[0]); end
      end
      step();
      if (acc) drive_a(1'b0, 10'd0);
    end
    n_checks++; if (a_lvl !== 5'd0 || a_mv !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got lvl=%0d tvalid=%b want 0 0", a_lvl, a_mv); end
    a_mr = 1'b0;
    b = {1'b1, 9'($urandom)};
    drive_a(1'b1, b);
    n_checks++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL bypass: got tvalid=%b want 0 before edge", a_mv); end
    step();
    drive_a(1'b0, 10'd0);
    n_checks++; if (a_mv !== 1'b1 || {a_ml, a_mk, a_md} !== b) begin n_fail++; $display("FAIL latency: got v=%b %h want 1 %h", a_mv, {a_ml, a_mk, a_md}, b); end
    n_checks++; if (a_pkt !== 5'd1) begin n_fail++; $display("FAIL latency_pkt: got %0d want 1", a_pkt); end
    a_mr = 1'b1;
    step();
    a_mr = 1'b0;
    n_checks++; if (a_lvl !== 5'd0 || a_pkt !== 5'd0) begin n_fail++; $display("FAIL latency_pop: got lvl=%0d pkt=%0d want 0 0", a_lvl, a_pkt); end
  endtask

  // 100 beats of full-rate streaming with 3 beats of slack, crossing the pointer wrap.
  task automatic test_stream();
    a_mr = 1'b0;
    repeat (3) begin drive_a(1'b1, {1'b0, 9'($urandom)}); step(); end
    a_mr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_a(1'b1, {1'($urandom_range(0, 3) == 0), 9'($urandom)});
      n_checks++; if (a_lvl !== 5'd3 || a_mv !== 1'b1 || a_sr !== 1'b1) begin n_fail++; $display("FAIL stream_rate[%0d]: got lvl=%0d v=%b r=%b want 3 1 1", i, a_lvl, a_mv, a_sr); end
      n_checks++; if ({a_ml, a_mk, a_md} !== qa[0]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, {a_ml, a_mk, a_md}, qa[0]); end
      step();
    end
    drive_a(1'b0, 10'd0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({a_ml, a_mk, a_md} !== qa[0]) begin n_fail++; $display("FAIL stream_tail[%0d]: got %h want %h", i, {a_ml, a_mk, a_md}, qa[0]); end
      step();
    end
    a_mr = 1'b0;
    n_checks++; if (a_lvl !== 5'd0 || a_pkt !== 5'(n_last(qa))) begin n_fail++; $display("FAIL stream_end: got lvl=%0d pkt=%0d want 0 0", a_lvl, a_pkt); end
  endtask

  // Packet mode holds a partial packet until its tlast beat is stored.
  task automatic test_pkt_hold();
    b_mr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_b(1'b1, {(i == 5), 9'($urandom)});
      n_checks++; if (b_mv !== 1'b0 || b_pkt !== 5'd0) begin n_fail++; $display("FAIL pkt_hold[%0d]: got v=%b pkt=%0d want 0 0", i, b_mv, b_pkt); end
      step();
    end
    drive_b(1'b0, 10'd0);
    n_checks++; if (b_mv !== 1'b1 || b_pkt !== 5'd1 || b_lvl !== 5'd6) begin n_fail++; $display("FAIL pkt_release: got v=%b pkt=%0d lvl=%0d want 1 1 6", b_mv, b_pkt, b_lvl); end
    for (int i = 0; i < 10 && qb.size() != 0; i++) begin
      n_checks++; if ({b_ml, b_mk, b_md} !== qb[0] || b_mv !== 1'b1) begin n_fail++; $display("FAIL pkt_data[%0d]: got v=%b %h want 1 %h", i, b_mv, {b_ml, b_mk, b_md}, qb[0]); end
      step();
    end
    n_checks++; if (b_pkt !== 5'd0 || b_lvl !== 5'd0 || b_mv !== 1'b0) begin n_fail++; $display("FAIL pkt_drained: got pkt=%0d lvl=%0d v=%b want 0 0 0", b_pkt, b_lvl, b_mv); end
  endtask

  // A 20-beat packet exceeds the depth and must be released by the full condition.
  task automatic test_long_pkt();
    int sent = 0, recv = 0;
    beat_t cur;
    b_mr = 1'b1;
    cur = {1'b0, 9'($urandom)};
    for (int i = 0; i < 200 && recv < 20; i++) begin
      bit acc;
      drive_b(sent < 20, cur);
      acc = b_sv && (qb.size() < D);
      n_checks++; if (b_mv !== exp_valid(1'b1, qb) || b_sr !== (qb.size() < D)) begin n_fail++; $display("FAIL long_hs[%0d]: got v=%b r=%b want %b %b", i, b_mv, b_sr, exp_valid(1'b1, qb), qb.size() < D); end
      n_checks++; if (b_lvl !== 5'(qb.size()) || b_pkt !== 5'(n_last(qb))) begin n_fail++; $display("FAIL long_cnt[%0d]: got lvl=%0d pkt=%0d want %0d %0d", i, b_lvl, b_pkt, qb.size(), n_last(qb)); end
      if (exp_valid(1'b1, qb)) begin
        recv++;
        n_checks++; if ({b_ml, b_mk, b_md} !== qb[0]) begin n_fail++; $display("FAIL long_data[%0d]: got %h want %h", recv, {b_ml, b_mk, b_md}, qb[0]); end
      end
      step();
      if (acc) begin sent++; cur = {(sent == 19), 9'($urandom)}; end
    end
    drive_b(1'b0, 10'd0);
    n_checks++; if (recv != 20 || b_lvl !== 5'd0) begin n_fail++; $display("FAIL long_done: got recv=%0d lvl=%0d want 20 0", recv, b_lvl); end
  endtask

  // Random traffic on both instances with random packet boundaries and backpressure.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_a(1'($urandom_range(0, 1)), {1'($urandom_range(0, 4) == 0), 9'($urandom)});
      drive_b(1'($urandom_range(0, 3) != 0), {1'($urandom_range(0, 4) == 0), 9'($urandom)});
      a_mr = 1'($urandom_range(0, 1));
      b_mr = 1'($urandom_range(0, 2) != 0);
      n_checks++; if (a_mv !== exp_valid(1'b0, qa) || a_sr !== (qa.size() < D) || a_lvl !== 5'(qa.size()) || a_pkt !== 5'(n_last(qa)) || a_af !== (qa.size() >= 14)) begin
        n_fail++; $display("FAIL rand_a_state[%0d]: got v=%b r=%b lvl=%0d pkt=%0d af=%b want lvl=%0d pkt=%0d", i, a_mv, a_sr, a_lvl, a_pkt, a_af, qa.size(), n_last(qa)); end
      n_checks++; if (b_mv !== exp_valid(1'b1, qb) || b_sr !== (qb.size() < D) || b_lvl !== 5'(qb.size()) || b_pkt !== 5'(n_last(qb)) || b_af !== (qb.size() >= 14)) begin
        n_fail++; $display("FAIL rand_b_state[%0d]: got v=%b r=%b lvl=%0d pkt=%0d af=%b want lvl=%0d pkt=%0d", i, b_mv, b_sr, b_lvl, b_pkt, b_af, qb.size(), n_last(qb)); end
      if (qa.size() != 0) begin
        n_checks++; if ({a_ml, a_mk, a_md} !== qa[0]) begin n_fail++; $display("FAIL rand_a_data[%0d]: got %h want %h", i, {a_ml, a_mk, a_md}, qa[0]); end
      end
      if (exp_valid(1'b1, qb)) begin
        n_checks++; if ({b_ml, b_mk, b_md} !== qb[0]) begin n_fail++; $display("FAIL rand_b_data[%0d]: got %h want %h", i, {b_ml, b_mk, b_md}, qb[0]); end
      end
      step();
    end
    idle();
  endtask

  // Asynchronous reset while a partial packet sits at level 7.
  task automatic test_reset_mid();
    idle();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    qa.delete(); qb.delete();
    step();
    for (int i = 0; i < 7; i++) begin
      drive_a(1'b1, {1'b0, 9'($urandom)});
      drive_b(1'b1, {1'b0, 9'($urandom)});
      step();
    end
    idle();
    n_checks++; if (a_lvl !== 5'd7 || b_lvl !== 5'd7 || a_mv !== 1'b1 || b_mv !== 1'b0) begin n_fail++; $display("FAIL mid_level: got %0d/%0d v=%b/%b want 7/7 1/0", a_lvl, b_lvl, a_mv, b_mv); end
    #2;
    rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete();
    n_checks++; if (a_mv !== 1'b0 || a_sr !== 1'b0 || a_lvl !== 5'd0 || b_lvl !== 5'd0 || {a_md, a_mk, a_ml} !== 10'd0) begin
      n_fail++; $display("FAIL mid_async: got v=%b r=%b lvl=%0d/%0d data=%h want 0 0 0/0 0", a_mv, a_sr, a_lvl, b_lvl, {a_md, a_mk, a_ml}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    n_checks++; if (a_lvl !== 5'd0 || b_lvl !== 5'd0 || a_mv !== 1'b0 || b_mv !== 1'b0 || a_pkt !== 5'd0 || b_pkt !== 5'd0) begin
      n_fail++; $display("FAIL mid_after: got lvl=%0d/%0d v=%b/%b pkt=%0d/%0d want zeros", a_lvl, b_lvl, a_mv, b_mv, a_pkt, b_pkt); end
    n_checks++; if (a_sr !== 1'b1 || b_sr !== 1'b1) begin n_fail++; $display("FAIL mid_tready: got %b/%b want 1/1", a_sr, b_sr); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_pkt_hold();
    test_long_pkt();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
